// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes,
// FSM encoding and the byte/half merge and extend helpers.
package mem_access_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_RMW_WR = 1'b1
   } state_t;

   function automatic logic [31:0] extend_load(input logic [2:0] funct3,
                                               input logic [31:0] rdata);
      logic [31:0] r;
      r = rdata;
      case (funct3)
         F3_B:    r = {{24{rdata[7]}}, rdata[7:0]};
         F3_H:    r = {{16{rdata[15]}}, rdata[15:0]};
         F3_BU:   r = {24'h000000, rdata[7:0]};
         F3_HU:   r = {16'h0000, rdata[15:0]};
         default: r = rdata;
      endcase
      return r;
   endfunction

   // Sub-word stores keep the untouched upper bytes of the current memory word.
   function automatic logic [31:0] merge_store(input logic [2:0] funct3,
                                               input logic [31:0] rdata,
                                               input logic [31:0] wdata);
      logic [31:0] r;
      r = wdata;
      case (funct3)
         F3_B:    r = {rdata[31:8], wdata[7:0]};
         F3_H:    r = {rdata[31:16], wdata[15:0]};
         default: r = wdata;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational data alignment: extended load word and merged store word.
module mem_align
   import mem_access_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] mem_rdata,
   input  logic [31:0] req_wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   assign load_data  = extend_load(funct3, mem_rdata);
   assign merge_data = merge_store(funct3, mem_rdata, req_wdata);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: funct3 decode, range check, SB/SH read-modify-write
// FSM and the registered MEM/WB load result.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int MEM_BYTES = 1025
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall_o,
   output logic        wb_valid_o,
   output logic [31:0] wb_data_o,
   output logic        fault_o,
   output logic        mem_ce,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   state_t      state, state_next;
   logic [31:0] merge_q;
   logic [31:0] load_word, merge_word;
   logic [32:0] last_byte;
   logic        in_range, f3_legal, legal;
   logic        load_ok, capture, fault_now;

   mem_align u_align (
      .funct3     (req_funct3),
      .mem_rdata  (mem_rdata),
      .req_wdata  (req_wdata),
      .load_data  (load_word),
      .merge_data (merge_word)
   );

   // The 33-bit sum keeps addresses near 2^32 from wrapping back into range.
   assign last_byte = {1'b0, req_addr} + 33'd3;
   assign in_range  = (last_byte <= 33'(MEM_BYTES - 1));
   assign legal     = in_range && f3_legal;
   assign mem_addr  = req_addr;

   always_comb begin
      f3_legal = 1'b0;
      if (req_we) begin
         f3_legal = (req_funct3 == F3_B) || (req_funct3 == F3_H) ||
                    (req_funct3 == F3_W);
      end else begin
         f3_legal = (req_funct3 == F3_B)  || (req_funct3 == F3_H) ||
                    (req_funct3 == F3_W)  || (req_funct3 == F3_BU) ||
                    (req_funct3 == F3_HU);
      end
   end

   // Memory strobes are gated by rst_n so a reset mid-RMW cancels the write at once.
   always_comb begin
      state_next = state;
      stall_o    = 1'b0;
      mem_ce     = 1'b0;
      mem_we     = 1'b0;
      mem_wdata  = req_wdata;
      load_ok    = 1'b0;
      capture    = 1'b0;
      fault_now  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid && rst_n) begin
               if (!legal) begin
                  fault_now = 1'b1;
               end else if (!req_we) begin
                  mem_ce  = 1'b1;
                  load_ok = 1'b1;
               end else if (req_funct3 == F3_W) begin
                  mem_ce = 1'b1;
                  mem_we = 1'b1;
               end else begin
                  mem_ce     = 1'b1;
                  stall_o    = 1'b1;
                  capture    = 1'b1;
                  state_next = ST_RMW_WR;
               end
            end
         end
         ST_RMW_WR: begin
            mem_ce     = rst_n;
            mem_we     = rst_n;
            mem_wdata  = merge_q;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         merge_q    <= 32'h0;
         wb_valid_o <= 1'b0;
         wb_data_o  <= 32'h0;
         fault_o    <= 1'b0;
      end else begin
         state      <= state_next;
         wb_valid_o <= load_ok;
         fault_o    <= fault_now;
         if (capture) begin
            merge_q <= merge_word;
         end
         if (load_ok) begin
            wb_data_o <= load_word;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table for single-cycle requests,
// hand-written sequences for SB/SH read-modify-write and reset during RMW.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        stall_o, wb_valid_o, fault_o, mem_ce, mem_we;
   logic [31:0] wb_data_o, mem_addr, mem_wdata, mem_rdata;

   logic [7:0]  memArr [0:2047];
   logic        preEn = 1'b0;
   logic [10:0] preAddr = 11'h0;
   logic [31:0] preData = 32'h0;

   int checks = 0;
   int errors = 0;

   mem_access_unit #(.MEM_BYTES(1025)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall_o    (stall_o),
      .wb_valid_o (wb_valid_o),
      .wb_data_o  (wb_data_o),
      .fault_o    (fault_o),
      .mem_ce     (mem_ce),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Byte-addressed little-endian data memory with a preload path for setup.
   assign mem_rdata = {memArr[mem_addr[10:0] + 11'd3], memArr[mem_addr[10:0] + 11'd2],
                       memArr[mem_addr[10:0] + 11'd1], memArr[mem_addr[10:0]]};

   always @(posedge clk) begin
      if (mem_ce && mem_we) begin
         for (int k = 0; k < 4; k++) begin
            memArr[mem_addr[10:0] + 11'(k)] <= mem_wdata[8*k +: 8];
         end
      end else if (preEn) begin
         for (int k = 0; k < 4; k++) begin
            memArr[preAddr + 11'(k)] <= preData[8*k +: 8];
         end
      end
   end

   typedef struct {
      string       name;
      logic        valid;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        expCe;
      logic        expWe;
      logic        expFault;
      logic        expWbValid;
      logic [31:0] expWbData;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string name, logic valid, logic we, logic [2:0] f3,
                               logic [31:0] addr, logic [31:0] wdata, logic expCe,
                               logic expWe, logic expFault, logic expWbValid,
                               logic [31:0] expWbData);
      vec_t v;
      v.name = name; v.valid = valid; v.we = we; v.f3 = f3; v.addr = addr;
      v.wdata = wdata; v.expCe = expCe; v.expWe = expWe; v.expFault = expFault;
      v.expWbValid = expWbValid; v.expWbData = expWbData;
      return v;
   endfunction

   function automatic logic [31:0] memWord(input logic [10:0] a);
      return {memArr[a + 11'd3], memArr[a + 11'd2], memArr[a + 11'd1], memArr[a]};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   task automatic preloadWord(input logic [10:0] a, input logic [31:0] d);
      @(negedge clk);
      preEn = 1'b1; preAddr = a; preData = d;
      @(posedge clk);
      #1 preEn = 1'b0;
   endtask

   task automatic driveReq(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
   endtask

   // One-cycle request: comb outputs checked mid-cycle, registered ones after the edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clk);
      driveReq(v.we, v.f3, v.addr, v.wdata);
      req_valid = v.valid;
      #1;
      checkOutput({v.name, " stall"}, {31'h0, stall_o}, 32'h0);
      checkOutput({v.name, " ce"}, {31'h0, mem_ce}, {31'h0, v.expCe});
      checkOutput({v.name, " we"}, {31'h0, mem_we}, {31'h0, v.expWe});
      if (v.expWe) checkOutput({v.name, " wdata"}, mem_wdata, v.wdata);
      @(posedge clk);
      #1;
      checkOutput({v.name, " fault"}, {31'h0, fault_o}, {31'h0, v.expFault});
      checkOutput({v.name, " wbValid"}, {31'h0, wb_valid_o}, {31'h0, v.expWbValid});
      if (v.expWbValid) checkOutput({v.name, " wbData"}, wb_data_o, v.expWbData);
      req_valid = 1'b0;
   endtask

   // SB/SH: stall with read first, then the merged word is written.
   task automatic rmwStore(input string name, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] expMerged);
      @(negedge clk);
      driveReq(1'b1, f3, addr, wdata);
      #1;
      checkOutput({name, " c0 stall"}, {31'h0, stall_o}, 32'h1);
      checkOutput({name, " c0 ce"}, {31'h0, mem_ce}, 32'h1);
      checkOutput({name, " c0 we"}, {31'h0, mem_we}, 32'h0);
      @(posedge clk);
      #1;
      checkOutput({name, " c1 stall"}, {31'h0, stall_o}, 32'h0);
      checkOutput({name, " c1 we"}, {31'h0, mem_we}, 32'h1);
      checkOutput({name, " c1 wdata"}, mem_wdata, expMerged);
      checkOutput({name, " c1 wbValid"}, {31'h0, wb_valid_o}, 32'h0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      checkOutput({name, " mem"}, memWord(addr[10:0]), expMerged);
   endtask

   initial begin
      rst_n = 1'b0;
      preloadWord(11'h010, 32'h8899AABB);
      preloadWord(11'h014, 32'h00000000);
      preloadWord(11'h3FD, 32'h0BADF00D);
      preloadWord(11'h020, 32'hDEADBEEF);
      preloadWord(11'h024, 32'h0000005A);
      preloadWord(11'h030, 32'h11223344);
      #1;
      checkOutput("reset stall", {31'h0, stall_o}, 32'h0);
      checkOutput("reset ce", {31'h0, mem_ce}, 32'h0);
      checkOutput("reset we", {31'h0, mem_we}, 32'h0);
      checkOutput("reset wbValid", {31'h0, wb_valid_o}, 32'h0);
      checkOutput("reset wbData", wb_data_o, 32'h0);
      checkOutput("reset fault", {31'h0, fault_o}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      vecs.push_back(mk("LW 0x10",   1, 0, 3'b010, 32'h10, 0, 1, 0, 0, 1, 32'h8899AABB));
      vecs.push_back(mk("LB 0x10",   1, 0, 3'b000, 32'h10, 0, 1, 0, 0, 1, 32'hFFFFFFBB));
      vecs.push_back(mk("LBU 0x10",  1, 0, 3'b100, 32'h10, 0, 1, 0, 0, 1, 32'h000000BB));
      vecs.push_back(mk("LH 0x10",   1, 0, 3'b001, 32'h10, 0, 1, 0, 0, 1, 32'hFFFFAABB));
      vecs.push_back(mk("LHU 0x10",  1, 0, 3'b101, 32'h10, 0, 1, 0, 0, 1, 32'h0000AABB));
      vecs.push_back(mk("LB 0x13",   1, 0, 3'b000, 32'h13, 0, 1, 0, 0, 1, 32'hFFFFFF88));
      vecs.push_back(mk("LW 0x3FD",  1, 0, 3'b010, 32'h3FD, 0, 1, 0, 0, 1, 32'h0BADF00D));
      vecs.push_back(mk("LW 0x3FE",  1, 0, 3'b010, 32'h3FE, 0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk("LW wrap",   1, 0, 3'b010, 32'hFFFFFFFE, 0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk("L f3 011",  1, 0, 3'b011, 32'h10, 0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk("L f3 110",  1, 0, 3'b110, 32'h10, 0, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk("S f3 100",  1, 1, 3'b100, 32'h10, 32'h1, 0, 0, 1, 0, 32'h0));
      vecs.push_back(mk("SW 0x40",   1, 1, 3'b010, 32'h40, 32'hCAFEBABE, 1, 1, 0, 0, 32'h0));
      vecs.push_back(mk("LW 0x40",   1, 0, 3'b010, 32'h40, 0, 1, 0, 0, 1, 32'hCAFEBABE));
      vecs.push_back(mk("idle",      0, 0, 3'b010, 32'h10, 0, 0, 0, 0, 0, 32'h0));
      foreach (vecs[i]) applyStimulus(vecs[i]);

      rmwStore("SB 0x20", 3'b000, 32'h20, 32'h12345677, 32'hDEADBE77);
      applyStimulus(mk("LW 0x20 after SB", 1, 0, 3'b010, 32'h20, 0, 1, 0, 0, 1, 32'hDEADBE77));
      rmwStore("SH 0x21", 3'b001, 32'h21, 32'h0000CAFE, 32'h5ADECAFE);
      applyStimulus(mk("LW 0x21 after SH", 1, 0, 3'b010, 32'h21, 0, 1, 0, 0, 1, 32'h5ADECAFE));

      @(negedge clk);
      driveReq(1'b1, 3'b000, 32'h30, 32'h000000AB);
      @(posedge clk);
      #1;
      checkOutput("rstRmw pre we", {31'h0, mem_we}, 32'h1);
      rst_n = 1'b0;
      #1;
      checkOutput("rstRmw we", {31'h0, mem_we}, 32'h0);
      checkOutput("rstRmw stall", {31'h0, stall_o}, 32'h0);
      checkOutput("rstRmw wbValid", {31'h0, wb_valid_o}, 32'h0);
      checkOutput("rstRmw wbData", wb_data_o, 32'h0);
      checkOutput("rstRmw fault", {31'h0, fault_o}, 32'h0);
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rstRmw mem", memWord(11'h030), 32'h11223344);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(mk("LW 0x30 after rst", 1, 0, 3'b010, 32'h30, 0, 1, 0, 0, 1, 32'h11223344));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
